icache_refill_ctrl: RTL and testbench

Sequences line refills of the instruction cache from the shared main-memory read port. It sits between the fetch stage's icache and the memory interface. On an icache miss it stalls fetch, issues a line-aligned read, streams the returned words into the cache data array, writes the tag/valid entry, then releases fetch to retry the same PC.

---
 rtl/icache_refill_ctrl.sv | 113 +++++++++++
 tb/tb_icache_refill_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
// Refills one instruction-cache line from the shared memory read port after a
// fetch miss. Fetch is stalled from the miss cycle until the line has been
// written and tagged. Words arrive in offset order 0..LINE_WORDS-1.

module icache_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             miss,
    input  logic [31:0]      miss_addr,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             fill_we,
    output logic [31:0]      fill_addr,
    output logic [OFF_W-1:0] fill_off,
    output logic [31:0]      fill_data,
    output logic             fill_tag_we,
    output logic             f_stall,
    output logic [31:0]      miss_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_WORDS - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [31:0]      r_line_addr;
    logic [OFF_W-1:0] r_off;
    logic [31:0]      r_miss_count;
    logic             w_start;
    logic             w_fill_we;
    logic             w_last_word;

    // A refill starts only from IDLE; misses seen in any other state are ignored.
    assign w_start     = (r_state == S_IDLE) && miss;
    assign w_last_word = w_fill_we && (r_off == LAST_OFF);

    // State register, latched line address, fill offset and miss counter.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others, independent of statement order.
        if (reset) begin
            r_state      <= S_IDLE;
            r_line_addr  <= '0;
            r_off        <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_line_addr <= {miss_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                r_off       <= '0;
                if (r_miss_count != 32'hFFFF_FFFF) begin
                    r_miss_count <= r_miss_count + 32'd1;
                end
            end else if (w_fill_we) begin
                // Wraps to zero after the last word, ready for the next refill.
                r_off <= r_off + 1'b1;
            end
        end
    end

    // Next-state and per-cycle memory/fill strobes, decoded without a register stage.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        w_next_state = r_state;
        mem_req      = 1'b0;
        w_fill_we    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (miss) w_next_state = S_REQ;
            end
            S_REQ: begin
                // Returned data before the grant is not part of this line.
                mem_req = 1'b1;
                if (mem_gnt) w_next_state = S_FILL;
            end
            S_FILL: begin
                w_fill_we = mem_rvalid;
                if (mem_rvalid && (r_off == LAST_OFF)) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign mem_addr    = r_line_addr;
    assign fill_addr   = r_line_addr;
    assign fill_we     = w_fill_we;
    assign fill_off    = r_off;
    assign fill_data   = mem_rdata;
    assign fill_tag_we = w_last_word;
    // Combinational so fetch is already held in the cycle the miss is seen.
    assign f_stall     = (r_state != S_IDLE) || miss;
    assign miss_count  = r_miss_count;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed testbench for icache_refill_ctrl (LINE_WORDS = 4).
// Inputs change just after the falling edge; outputs are sampled 1 ns later,
// well before the next rising edge.

module tb_icache_refill_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        miss = 1'b0;
    logic [31:0] miss_addr = '0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        fill_we;
    logic [31:0] fill_addr;
    logic [1:0]  fill_off;
    logic [31:0] fill_data;
    logic        fill_tag_we;
    logic        f_stall;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    icache_refill_ctrl #(.LINE_WORDS(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .miss        (miss),
        .miss_addr   (miss_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .fill_we     (fill_we),
        .fill_addr   (fill_addr),
        .fill_off    (fill_off),
        .fill_data   (fill_data),
        .fill_tag_we (fill_tag_we),
        .f_stall     (f_stall),
        .miss_count  (miss_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply one cycle of inputs after the falling edge, then settle.
    task automatic step(input logic m, input logic [31:0] a, input logic g,
                        input logic rv, input logic [31:0] d);
        @(negedge clock);
        miss       = m;
        miss_addr  = a;
        mem_gnt    = g;
        mem_rvalid = rv;
        mem_rdata  = d;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if ({mem_req, fill_we, fill_tag_we, f_stall, fill_off} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {mem_req, fill_we, fill_tag_we, f_stall, fill_off});
        end
        n_checks++;
        if ({mem_addr, fill_addr, miss_count} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_regs: mem_addr=%h fill_addr=%h miss_count=%h expected all zero",
                     mem_addr, fill_addr, miss_count);
        end
        // f_stall follows miss even while reset is held.
        step(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (f_stall !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: f_stall=%b mem_req=%b expected 1 0", f_stall, mem_req);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (miss_count !== 32'd0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_exit: miss_count=%h mem_req=%b expected 0 0", miss_count, mem_req);
        end
    endtask

    task automatic test_basic_refill();
        // Expected {mem_req, fill_we, fill_tag_we, f_stall, fill_off[1:0]} per cycle.
        logic [5:0]  exp [8] = '{6'b000100, 6'b100100, 6'b010100, 6'b010101,
                                 6'b010110, 6'b011111, 6'b000100, 6'b000000};
        logic [7:0]  m_v  = 8'b0011_1111;
        logic [7:0]  g_v  = 8'b0000_0010;
        logic [7:0]  rv_v = 8'b0011_1100;
        logic [31:0] d;
        int          stalls = 0;
        for (int i = 0; i < 8; i++) begin
            d = 32'hA0A0_0000 + 32'(i - 2);
            step(m_v[i], 32'h0000_1234, g_v[i], rv_v[i], d);
            if (f_stall === 1'b1) stalls++;
            n_checks++;
            if ({mem_req, fill_we, fill_tag_we, f_stall, fill_off} !== exp[i]) begin
                n_fail++;
                $display("FAIL basic_ctrl[%0d]: got %b expected %b", i,
                         {mem_req, fill_we, fill_tag_we, f_stall, fill_off}, exp[i]);
            end
            if (i == 1) begin
                n_checks++;
                if (mem_addr !== 32'h0000_1230) begin
                    n_fail++;
                    $display("FAIL basic_mem_addr: got %h expected 00001230", mem_addr);
                end
            end
            if (i >= 2 && i <= 5) begin
                n_checks++;
                if (fill_data !== d || fill_addr !== 32'h0000_1230) begin
                    n_fail++;
                    $display("FAIL basic_fill[%0d]: data=%h addr=%h expected %h 00001230",
                             i, fill_data, fill_addr, d);
                end
            end
        end
        n_checks++;
        if (stalls !== 7) begin
            n_fail++;
            $display("FAIL basic_stall_len: got %0d expected 7", stalls);
        end
        n_checks++;
        if (miss_count !== 32'd1) begin
            n_fail++;
            $display("FAIL basic_miss_count: got %0d expected 1", miss_count);
        end
    endtask

    task automatic test_delayed_grant();
        logic [5:0]  exp [11] = '{6'b000100, 6'b100100, 6'b100100, 6'b100100,
                                  6'b100100, 6'b010100, 6'b010101, 6'b010110,
                                  6'b011111, 6'b000100, 6'b000000};
        logic [10:0] m_v  = 11'b001_1111_1111;
        logic [10:0] g_v  = 11'b000_0001_0000;
        logic [10:0] rv_v = 11'b001_1110_0100;
        logic [31:0] d;
        int          reqs = 0;
        for (int i = 0; i < 11; i++) begin
            d = (i == 2) ? 32'hDEAD_BEEF : 32'hB0B0_0000 + 32'(i - 5);
            step(m_v[i], 32'h0000_2468, g_v[i], rv_v[i], d);
            n_checks++;
            if ({mem_req, fill_we, fill_tag_we, f_stall, fill_off} !== exp[i]) begin
                n_fail++;
                $display("FAIL delayed_ctrl[%0d]: got %b expected %b", i,
                         {mem_req, fill_we, fill_tag_we, f_stall, fill_off}, exp[i]);
            end
            if (mem_req === 1'b1) begin
                reqs++;
                n_checks++;
                if (mem_addr !== 32'h0000_2460) begin
                    n_fail++;
                    $display("FAIL delayed_mem_addr[%0d]: got %h expected 00002460", i, mem_addr);
                end
            end
            if (i >= 5 && i <= 8) begin
                n_checks++;
                if (fill_data !== d) begin
                    n_fail++;
                    $display("FAIL delayed_fill_data[%0d]: got %h expected %h", i, fill_data, d);
                end
            end
        end
        n_checks++;
        if (reqs !== 4) begin
            n_fail++;
            $display("FAIL delayed_req_len: got %0d expected 4", reqs);
        end
    endtask

    task automatic test_gapped_data();
        logic [5:0]  exp [11] = '{6'b000100, 6'b100100, 6'b010100, 6'b000101,
                                  6'b010101, 6'b000110, 6'b010110, 6'b000111,
                                  6'b011111, 6'b000100, 6'b000000};
        logic [10:0] m_v  = 11'b001_1111_1111;
        logic [10:0] g_v  = 11'b000_0000_0010;
        logic [10:0] rv_v = 11'b001_0101_0100;
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < 11; i++) begin
            // Fetch redirects to another PC mid-refill; the line must still complete.
            a = (i < 2) ? 32'h0000_0ABC : 32'h0000_9990;
            d = 32'hC0C0_0000 + 32'((i - 2) / 2);
            step(m_v[i], a, g_v[i], rv_v[i], d);
            n_checks++;
            if ({mem_req, fill_we, fill_tag_we, f_stall, fill_off} !== exp[i]) begin
                n_fail++;
                $display("FAIL gapped_ctrl[%0d]: got %b expected %b", i,
                         {mem_req, fill_we, fill_tag_we, f_stall, fill_off}, exp[i]);
            end
            if (rv_v[i]) begin
                n_checks++;
                if (fill_data !== d || fill_addr !== 32'h0000_0AB0) begin
                    n_fail++;
                    $display("FAIL gapped_fill[%0d]: data=%h addr=%h expected %h 00000AB0",
                             i, fill_data, fill_addr, d);
                end
            end
        end
        n_checks++;
        if (miss_count !== 32'd3) begin
            n_fail++;
            $display("FAIL gapped_miss_count: got %0d expected 3", miss_count);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [5:0] exp [8] = '{6'b000100, 6'b100100, 6'b010100, 6'b010101,
                                6'b000110, 6'b000000, 6'b000000, 6'b000000};
        logic [7:0] m_v  = 8'b0000_1111;
        logic [7:0] g_v  = 8'b0000_0010;
        logic [7:0] rv_v = 8'b1110_1100;
        int         tags = 0;
        for (int i = 0; i < 8; i++) begin
            step(m_v[i], 32'h0000_0300, g_v[i], rv_v[i], 32'h5555_0000 + 32'(i));
            reset = (i == 4);
            if (fill_tag_we === 1'b1) tags++;
            n_checks++;
            if ({mem_req, fill_we, fill_tag_we, f_stall, fill_off} !== exp[i]) begin
                n_fail++;
                $display("FAIL rstmid_ctrl[%0d]: got %b expected %b", i,
                         {mem_req, fill_we, fill_tag_we, f_stall, fill_off}, exp[i]);
            end
        end
        reset = 1'b0;
        n_checks++;
        if (tags !== 0) begin
            n_fail++;
            $display("FAIL rstmid_tag_we: got %0d tag writes expected 0", tags);
        end
        n_checks++;
        if (miss_count !== 32'd0 || fill_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_regs: miss_count=%h fill_addr=%h expected 0 0",
                     miss_count, fill_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  exp [15] = '{6'b000100, 6'b100100, 6'b010100, 6'b010101,
                                  6'b010110, 6'b011111, 6'b000100, 6'b000100,
                                  6'b100100, 6'b010100, 6'b010101, 6'b010110,
                                  6'b011111, 6'b000100, 6'b000000};
        logic [15:0] m_v  = 16'h1FBF;
        logic [15:0] g_v  = 16'h0102;
        logic [15:0] rv_v = 16'h1E3C;
        logic [31:0] a;
        for (int i = 0; i < 15; i++) begin
            a = (i < 7) ? 32'h0000_0100 : 32'h0000_0200;
            step(m_v[i], a, g_v[i], rv_v[i], 32'h7000_0000 + 32'(i));
            n_checks++;
            if ({mem_req, fill_we, fill_tag_we, f_stall, fill_off} !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_ctrl[%0d]: got %b expected %b", i,
                         {mem_req, fill_we, fill_tag_we, f_stall, fill_off}, exp[i]);
            end
            if (i == 1 || i == 8) begin
                n_checks++;
                if (mem_addr !== a) begin
                    n_fail++;
                    $display("FAIL b2b_mem_addr[%0d]: got %h expected %h", i, mem_addr, a);
                end
            end
        end
        n_checks++;
        if (miss_count !== 32'd2) begin
            n_fail++;
            $display("FAIL b2b_miss_count: got %0d expected 2", miss_count);
        end
    endtask

    task automatic test_saturation();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        force dut.r_miss_count = 32'hFFFF_FFFF;
        // Miss seen while the counter reads all ones.
        step(1'b1, 32'h0000_0400, 1'b0, 1'b0, 32'h0);
        @(posedge clock);
        #1;
        release dut.r_miss_count;
        step(1'b0, 32'h0000_0400, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (miss_count !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_first: got %h expected ffffffff", miss_count);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        // Second miss from a saturated count.
        step(1'b1, 32'h0000_0500, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h0000_0500, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (miss_count !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_second: got %h expected ffffffff", miss_count);
        end
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0500) begin
            n_fail++;
            $display("FAIL sat_req: mem_req=%b mem_addr=%h expected 1 00000500", mem_req, mem_addr);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (f_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_release: f_stall=%b expected 0", f_stall);
        end
    endtask

    initial begin
        test_reset();
        test_basic_refill();
        test_delayed_grant();
        test_gapped_data();
        test_reset_mid_fill();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
